// File: rtl/sc_microseq_pkg.sv
// Shared types and code points for the microsequencer: states, register/ALU/clear codes, branch conditions.
package sc_microseq_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    LOAD_IR = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    BRANCH  = 3'd4,
    PC_INC  = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam logic [5:0] R_R0    = 6'd1;
  localparam logic [5:0] R_R1    = 6'd2;
  localparam logic [5:0] R_R2    = 6'd3;
  localparam logic [5:0] R_R3    = 6'd4;
  localparam logic [5:0] R_RS    = 6'd5;
  localparam logic [5:0] R_PC    = 6'd6;
  localparam logic [5:0] R_IR    = 6'd7;
  localparam logic [5:0] R_TEMP0 = 6'd8;
  localparam logic [5:0] C_NONE  = 6'd15;

  localparam logic [3:0] ALU_PASSA = 4'h0;
  localparam logic [3:0] ALU_INC4  = 4'hE;
  localparam logic [3:0] ALU_BRADD = 4'hF;

  localparam logic [3:0] CLR_NONE = 4'h0;

  localparam logic [3:0] COND_BN  = 4'b0000;
  localparam logic [3:0] COND_BE  = 4'b0001;
  localparam logic [3:0] COND_BL  = 4'b0011;
  localparam logic [3:0] COND_BA  = 4'b1000;
  localparam logic [3:0] COND_BNE = 4'b1001;
  localparam logic [3:0] COND_BGE = 4'b1011;

  // Bit positions inside the condition-code register {V,C,N,Z}.
  localparam int CC_Z = 0;
  localparam int CC_N = 1;
  localparam int CC_C = 2;
  localparam int CC_V = 3;

endpackage

// File: rtl/sc_microseq_cond.sv
// Bicc condition evaluator (built only with MICROSEQ_BRANCH_EN): cond x cc -> taken / illegal.
module sc_microseq_cond
  import sc_microseq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken,
  output logic       illegal
);

  logic unused_carry;
  assign unused_carry = cc[CC_C];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_BA:  taken = 1'b1;
      COND_BN:  taken = 1'b0;
      COND_BE:  taken = cc[CC_Z];
      COND_BNE: taken = ~cc[CC_Z];
      COND_BL:  taken = cc[CC_N] ^ cc[CC_V];
      COND_BGE: taken = ~(cc[CC_N] ^ cc[CC_V]);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sc_microsequencer.sv
// Fetch/decode/execute control unit for the register/ALU datapath, Moore outputs, 4-bit cc register.
// Optional Bicc execution with macro MICROSEQ_BRANCH_EN; without it Bicc decodes as a NOP.
module sc_microsequencer
  import sc_microseq_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATA_BUS_CONTROL        = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int MEM_TIMEOUT             = 15
) (
  input  logic                               SC_MICROSEQ_CLOCK_50,
  input  logic                               SC_MICROSEQ_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]           SC_MICROSEQ_IR_InBUS,
  input  logic [3:0]                         SC_MICROSEQ_flags_InLow,
  input  logic                               SC_MICROSEQ_memack_InHigh,
  output logic                               SC_MICROSEQ_memrd_OutHigh,
  output logic [DATA_BUS_CONTROL-1:0]        SC_MICROSEQ_ctrlA_OutBUS,
  output logic [DATA_BUS_CONTROL-1:0]        SC_MICROSEQ_ctrlB_OutBUS,
  output logic [DATA_BUS_CONTROL-1:0]        SC_MICROSEQ_ctrlC_OutBUS,
  output logic                               SC_MICROSEQ_selA_Out,
  output logic                               SC_MICROSEQ_selB_Out,
  output logic                               SC_MICROSEQ_selC_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] SC_MICROSEQ_alusel_OutBUS,
  output logic [3:0]                         SC_MICROSEQ_clrsel_OutBUS,
  output logic                               SC_MICROSEQ_error_OutHigh,
  output logic [2:0]                         SC_MICROSEQ_state_OutBUS
);

  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic [3:0] cc;
  logic       fetch_rd;

  logic [1:0] op;
  logic [5:0] op3;
  logic [2:0] op2;
  logic       alu_ok, bicc;

  assign op  = SC_MICROSEQ_IR_InBUS[31:30];
  assign op3 = SC_MICROSEQ_IR_InBUS[24:19];
  assign op2 = SC_MICROSEQ_IR_InBUS[24:22];
  // op3[4] selects the cc-setting variant, so both the plain and cc forms are legal ALU ops.
  assign alu_ok = (op == 2'b10) && !op3[5] && !SC_MICROSEQ_IR_InBUS[13];
  assign bicc   = (op == 2'b00) && (op2 == 3'b010);

  logic unused_ir;
  assign unused_ir = ^{SC_MICROSEQ_IR_InBUS[29:25], SC_MICROSEQ_IR_InBUS[18:14],
                       SC_MICROSEQ_IR_InBUS[12:0]};

`ifdef MICROSEQ_BRANCH_EN
  logic br_taken, br_illegal;

  sc_microseq_cond u_cond (
    .cond    (SC_MICROSEQ_IR_InBUS[28:25]),
    .cc      (cc),
    .taken   (br_taken),
    .illegal (br_illegal)
  );
`endif

  always_ff @(posedge SC_MICROSEQ_CLOCK_50 or negedge SC_MICROSEQ_RESET_InLow) begin
    if (!SC_MICROSEQ_RESET_InLow) begin
      state <= FETCH;
      cnt   <= 4'd0;
      cc    <= 4'd0;
    end else begin
      state <= state_next;
      if (state == FETCH && !SC_MICROSEQ_memack_InHigh) cnt <= cnt + 4'd1;
      else if (state == LOAD_IR)                        cnt <= 4'd0;
      if (state == EXEC && op3[4]) cc <= ~SC_MICROSEQ_flags_InLow;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (SC_MICROSEQ_memack_InHigh)  state_next = LOAD_IR;
        else if (cnt == TIMEOUT_LAST)   state_next = ERROR;
      end
      LOAD_IR: state_next = DECODE;
      DECODE: begin
        if (alu_ok)    state_next = EXEC;
`ifdef MICROSEQ_BRANCH_EN
        else if (bicc) state_next = BRANCH;
`else
        else if (bicc) state_next = PC_INC;
`endif
        else           state_next = ERROR;
      end
      EXEC: state_next = PC_INC;
`ifdef MICROSEQ_BRANCH_EN
      BRANCH: begin
        if (br_illegal)    state_next = ERROR;
        else if (br_taken) state_next = FETCH;
        else               state_next = PC_INC;
      end
`endif
      PC_INC:  state_next = FETCH;
      ERROR:   state_next = ERROR;
      default: state_next = ERROR;
    endcase
  end

  always_comb begin
    fetch_rd                  = 1'b0;
    SC_MICROSEQ_ctrlA_OutBUS  = DATA_BUS_CONTROL'(R_PC);
    SC_MICROSEQ_ctrlB_OutBUS  = DATA_BUS_CONTROL'(R_PC);
    SC_MICROSEQ_ctrlC_OutBUS  = DATA_BUS_CONTROL'(C_NONE);
    SC_MICROSEQ_selA_Out      = 1'b0;
    SC_MICROSEQ_selB_Out      = 1'b0;
    SC_MICROSEQ_selC_Out      = 1'b0;
    SC_MICROSEQ_alusel_OutBUS = DATAWIDTH_ALU_SELECTION'(ALU_PASSA);
    case (state)
      FETCH:   fetch_rd = 1'b1;
      LOAD_IR: SC_MICROSEQ_ctrlC_OutBUS = DATA_BUS_CONTROL'(R_IR);
      EXEC: begin
        SC_MICROSEQ_selA_Out      = 1'b1;
        SC_MICROSEQ_selB_Out      = 1'b1;
        SC_MICROSEQ_selC_Out      = 1'b1;
        SC_MICROSEQ_alusel_OutBUS = DATAWIDTH_ALU_SELECTION'(op3[3:0]);
      end
`ifdef MICROSEQ_BRANCH_EN
      BRANCH: begin
        if (br_taken && !br_illegal) begin
          SC_MICROSEQ_ctrlB_OutBUS  = DATA_BUS_CONTROL'(R_IR);
          SC_MICROSEQ_ctrlC_OutBUS  = DATA_BUS_CONTROL'(R_PC);
          SC_MICROSEQ_alusel_OutBUS = DATAWIDTH_ALU_SELECTION'(ALU_BRADD);
        end
      end
`endif
      PC_INC: begin
        SC_MICROSEQ_ctrlC_OutBUS  = DATA_BUS_CONTROL'(R_PC);
        SC_MICROSEQ_alusel_OutBUS = DATAWIDTH_ALU_SELECTION'(ALU_INC4);
      end
      default: ;
    endcase
  end

  // The read request must drop while reset is held, even though the state already reads FETCH.
  assign SC_MICROSEQ_memrd_OutHigh = fetch_rd && SC_MICROSEQ_RESET_InLow;
  assign SC_MICROSEQ_clrsel_OutBUS = CLR_NONE;
  assign SC_MICROSEQ_error_OutHigh = (state == ERROR);
  assign SC_MICROSEQ_state_OutBUS  = state;

endmodule

// File: tb/tb_sc_microsequencer.sv
// Bench for sc_microsequencer: directed cases then random instructions against a per-instruction model.
module tb_sc_microsequencer;
  import sc_microseq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        memack;

  wire        memrd, sel_a, sel_b, sel_c, err_o;
  wire [5:0]  ctrl_a, ctrl_b, ctrl_c;
  wire [3:0]  alusel, clrsel;
  wire [2:0]  st_o;

  always #5 clk = ~clk;

  sc_microsequencer dut (
    .SC_MICROSEQ_CLOCK_50      (clk),
    .SC_MICROSEQ_RESET_InLow   (rst_n),
    .SC_MICROSEQ_IR_InBUS      (ir),
    .SC_MICROSEQ_flags_InLow   (flags),
    .SC_MICROSEQ_memack_InHigh (memack),
    .SC_MICROSEQ_memrd_OutHigh (memrd),
    .SC_MICROSEQ_ctrlA_OutBUS  (ctrl_a),
    .SC_MICROSEQ_ctrlB_OutBUS  (ctrl_b),
    .SC_MICROSEQ_ctrlC_OutBUS  (ctrl_c),
    .SC_MICROSEQ_selA_Out      (sel_a),
    .SC_MICROSEQ_selB_Out      (sel_b),
    .SC_MICROSEQ_selC_Out      (sel_c),
    .SC_MICROSEQ_alusel_OutBUS (alusel),
    .SC_MICROSEQ_clrsel_OutBUS (clrsel),
    .SC_MICROSEQ_error_OutHigh (err_o),
    .SC_MICROSEQ_state_OutBUS  (st_o)
  );

  int errs = 0;
  int checks = 0;
  logic [3:0] m_cc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input logic [2:0] st, input logic rd, input logic [5:0] ca,
                                     input logic [5:0] cb, input logic [5:0] cc_, input logic sa,
                                     input logic sb, input logic sc, input logic [3:0] alu,
                                     input logic [3:0] clr, input logic er);
    return {30'd0, st, rd, ca, cb, cc_, sa, sb, sc, alu, clr, er};
  endfunction

  task automatic expect_out(input string tag, input state_t st, input logic rd, input logic [5:0] ca,
                            input logic [5:0] cb, input logic [5:0] cc_, input logic sel,
                            input logic [3:0] alu);
    chk(tag, pk(st_o, memrd, ctrl_a, ctrl_b, ctrl_c, sel_a, sel_b, sel_c, alusel, clrsel, err_o),
        pk(st, rd, ca, cb, cc_, sel, sel, sel, alu, CLR_NONE, st == ERROR));
  endtask

  task automatic expect_idle(input string tag, input state_t st);
    expect_out(tag, st, 1'b0, R_PC, R_PC, C_NONE, 1'b0, ALU_PASSA);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    expect_idle("reset_async", FETCH);
    m_cc = 4'd0;
    chk("reset_cc", dut.cc, m_cc);
    repeat (2) @(negedge clk);
    expect_idle("reset_hold", FETCH);
    rst_n = 1'b1;
    #1;
  endtask

  // Runs one instruction starting in FETCH; waitc = FETCH cycles before memack (>=15 means never).
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input int waitc,
                           input bit abort_exec, output bit need_reset);
    bit alu_ok, bicc, taken, illeg;
    need_reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      expect_out("fetch", FETCH, 1'b1, R_PC, R_PC, C_NONE, 1'b0, ALU_PASSA);
      memack = (k == waitc);
      ir     = $urandom;
      flags  = 4'($urandom);
      @(negedge clk);
      if (k == waitc) break;
    end
    if (waitc >= 15) begin
      for (int k = 0; k < 3; k++) begin
        expect_idle("timeout_err", ERROR);
        memack = 1'($urandom);
        @(negedge clk);
      end
      need_reset = 1'b1;
      return;
    end
    expect_out("load_ir", LOAD_IR, 1'b0, R_PC, R_PC, R_IR, 1'b0, ALU_PASSA);
    memack = 1'($urandom);
    ir     = ins;
    @(negedge clk);
    expect_idle("decode", DECODE);
    alu_ok = (ins[31:30] == 2'b10) && !ins[24] && !ins[13];
    bicc   = (ins[31:30] == 2'b00) && (ins[24:22] == 3'b010);
    memack = 1'($urandom);
    flags  = fl;
    @(negedge clk);
    if (alu_ok) begin
      expect_out("exec", EXEC, 1'b0, R_PC, R_PC, C_NONE, 1'b1, ins[22:19]);
      if (abort_exec) return;
      memack = 1'($urandom);
      @(negedge clk);
      if (ins[23]) m_cc = ~fl;
      chk("cc_after_exec", dut.cc, m_cc);
    end else if (bicc) begin
`ifdef MICROSEQ_BRANCH_EN
      taken = 1'b0;
      illeg = 1'b0;
      case (ins[28:25])
        4'b1000: taken = 1'b1;
        4'b0000: taken = 1'b0;
        4'b0001: taken = m_cc[0];
        4'b1001: taken = !m_cc[0];
        4'b0011: taken = m_cc[1] ^ m_cc[3];
        4'b1011: taken = !(m_cc[1] ^ m_cc[3]);
        default: illeg = 1'b1;
      endcase
      memack = 1'($urandom);
      if (taken) begin
        expect_out("br_taken", BRANCH, 1'b0, R_PC, R_IR, R_PC, 1'b0, ALU_BRADD);
        @(negedge clk);
        return;
      end
      expect_idle("br_not_taken", BRANCH);
      @(negedge clk);
      if (illeg) begin
        expect_idle("br_illegal", ERROR);
        need_reset = 1'b1;
        return;
      end
`else
      taken = 1'b0;
      illeg = 1'b0;
`endif
    end else begin
      expect_idle("illegal", ERROR);
      need_reset = 1'b1;
      return;
    end
    expect_out("pc_inc", PC_INC, 1'b0, R_PC, R_PC, R_PC, 1'b0, ALU_INC4);
    memack = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic recover();
    memack = 1'b1;
    @(negedge clk);
    expect_idle("error_sticky", ERROR);
    do_reset();
  endtask

  function automatic logic [31:0] mk_alu(input logic [5:0] op3, input logic ibit);
    logic [31:0] v;
    v = $urandom;
    v[31:30] = 2'b10;
    v[24:19] = op3;
    v[13]    = ibit;
    return v;
  endfunction

  function automatic logic [31:0] mk_bicc(input logic [3:0] cond);
    logic [31:0] v;
    v = $urandom;
    v[31:30] = 2'b00;
    v[24:22] = 3'b010;
    v[28:25] = cond;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit nr;
    logic [3:0]  conds [6];
    logic [31:0] v;
    int          w;
    conds = '{4'b1000, 4'b0000, 4'b0001, 4'b1001, 4'b0011, 4'b1011};
    rst_n  = 1'b0;
    memack = 1'b0;
    ir     = 32'd0;
    flags  = 4'hF;
    m_cc   = 4'd0;
    @(negedge clk);
    expect_idle("reset_state", FETCH);
    chk("reset_cc", dut.cc, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    run_instr(32'h86004002, 4'b1110, 1, 1'b0, nr);              // ADD, memack on 2nd FETCH
    run_instr(mk_alu(6'b010100, 1'b0), 4'b1110, 0, 1'b0, nr);   // SUBcc -> cc=0001
    chk("subcc_cc", dut.cc, 4'b0001);
    run_instr(32'h02800004, 4'b0000, 0, 1'b0, nr);              // BE with Z set
    run_instr(mk_alu(6'b010100, 1'b0), 4'b1111, 2, 1'b0, nr);   // cc -> 0000
    run_instr(32'h02800004, 4'b0000, 0, 1'b0, nr);              // BE with Z clear
    run_instr(32'h86004002, 4'b0101, 14, 1'b0, nr);             // last FETCH cycle before timeout
    run_instr(32'h86004002, 4'b0000, 15, 1'b0, nr);             // timeout
    if (nr) recover();
    else chk("timeout_flag", 32'd0, 32'd1);
    run_instr(32'hC0000000, 4'b0000, 0, 1'b0, nr);              // op=11
    if (nr) recover();
    else chk("op11_flag", 32'd0, 32'd1);
    run_instr(mk_alu(6'b011010, 1'b0), 4'b0000, 1, 1'b1, nr);   // reset while in EXEC
    do_reset();

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       v = mk_alu({2'b00, 4'($urandom)}, 1'b0);
        1:       v = mk_alu({1'b0, 5'($urandom)}, 1'b0);
        2:       v = mk_alu(6'($urandom), 1'($urandom));
        3:       v = mk_bicc(conds[$urandom_range(0, 5)]);
        4:       v = mk_bicc(4'($urandom));
        default: begin
          v = $urandom;
          if (v[31:30] == 2'b10) v[31:30] = 2'b11;
        end
      endcase
      w = ($urandom_range(0, 29) == 0) ? 15 : $urandom_range(0, 4);
      run_instr(v, 4'($urandom), w, 1'b0, nr);
      if (nr) recover();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
